// File: rtl/boundary_scan_chain_pkg.sv
// Shared TAP state encoding and instruction opcodes for the boundary-scan chain.
package bscan_pkg;

  typedef enum logic [3:0] {
    TLR      = 4'd0,
    RTI      = 4'd1,
    SEL_DR   = 4'd2,
    CAP_DR   = 4'd3,
    SHIFT_DR = 4'd4,
    EXIT1_DR = 4'd5,
    PAUSE_DR = 4'd6,
    EXIT2_DR = 4'd7,
    UPD_DR   = 4'd8,
    SEL_IR   = 4'd9,
    CAP_IR   = 4'd10,
    SHIFT_IR = 4'd11,
    EXIT1_IR = 4'd12,
    PAUSE_IR = 4'd13,
    EXIT2_IR = 4'd14,
    UPD_IR   = 4'd15
  } tap_state_e;

  localparam int unsigned IR_WIDTH_DEF = 2;

  // BYPASS is all ones at whatever IR width is instantiated; slice to fit.
  localparam logic [31:0] OP_EXTEST = 32'd0;
  localparam logic [31:0] OP_SAMPLE = 32'd1;
  localparam logic [31:0] OP_BYPASS = '1;

endpackage

// File: rtl/boundary_scan_chain_if.sv
// Test-port and core/pin signals of the boundary-scan chain, named from the chain's side.
interface boundary_scan_chain_if #(
  parameter int N_CELLS = 8
);
  logic               tms_i;
  logic               tdi_i;
  logic               tdo_o;
  logic               tdo_en_o;
  logic [N_CELLS-1:0] core_in_i;
  logic [N_CELLS-1:0] pin_out_o;

  modport master (output tms_i, tdi_i, core_in_i, input tdo_o, tdo_en_o, pin_out_o);
  modport slave  (input tms_i, tdi_i, core_in_i, output tdo_o, tdo_en_o, pin_out_o);
endinterface

// File: rtl/boundary_scan_chain_tap_controller.sv
// 16-state TAP controller; state and action strobes are registered together.
module tap_controller
  import bscan_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       tms_i,
  output tap_state_e state_o,
  output logic       capture_dr_o,
  output logic       shift_dr_o,
  output logic       update_dr_o,
  output logic       capture_ir_o,
  output logic       shift_ir_o,
  output logic       update_ir_o,
  output logic       tlr_o
);

  tap_state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TLR:      state_d = tms_i ? TLR      : RTI;
      RTI:      state_d = tms_i ? SEL_DR   : RTI;
      SEL_DR:   state_d = tms_i ? SEL_IR   : CAP_DR;
      CAP_DR:   state_d = tms_i ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: state_d = tms_i ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: state_d = tms_i ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: state_d = tms_i ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: state_d = tms_i ? UPD_DR   : SHIFT_DR;
      UPD_DR:   state_d = tms_i ? SEL_DR   : RTI;
      SEL_IR:   state_d = tms_i ? TLR      : CAP_IR;
      CAP_IR:   state_d = tms_i ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: state_d = tms_i ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: state_d = tms_i ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: state_d = tms_i ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: state_d = tms_i ? UPD_IR   : SHIFT_IR;
      UPD_IR:   state_d = tms_i ? SEL_DR   : RTI;
      default:  state_d = TLR;
    endcase
  end

  // Strobes are decoded from the next state so they line up with state_q.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= TLR;
      capture_dr_o <= 1'b0;
      shift_dr_o   <= 1'b0;
      update_dr_o  <= 1'b0;
      capture_ir_o <= 1'b0;
      shift_ir_o   <= 1'b0;
      update_ir_o  <= 1'b0;
      tlr_o        <= 1'b1;
    end else begin
      state_q      <= state_d;
      capture_dr_o <= (state_d == CAP_DR);
      shift_dr_o   <= (state_d == SHIFT_DR);
      update_dr_o  <= (state_d == UPD_DR);
      capture_ir_o <= (state_d == CAP_IR);
      shift_ir_o   <= (state_d == SHIFT_IR);
      update_ir_o  <= (state_d == UPD_IR);
      tlr_o        <= (state_d == TLR);
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/boundary_scan_chain.sv
// Boundary-scan register with IR, bypass flop and TDO mux, sequenced by an internal TAP.
module boundary_scan_chain
  import bscan_pkg::*;
#(
  parameter int N_CELLS  = 8,
  parameter int IR_WIDTH = IR_WIDTH_DEF
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  boundary_scan_chain_if.slave          bus
);

  localparam logic [IR_WIDTH-1:0] IR_EXTEST  = OP_EXTEST[IR_WIDTH-1:0];
  localparam logic [IR_WIDTH-1:0] IR_SAMPLE  = OP_SAMPLE[IR_WIDTH-1:0];
  localparam logic [IR_WIDTH-1:0] IR_BYPASS  = OP_BYPASS[IR_WIDTH-1:0];
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);

  tap_state_e tap_state;
  logic capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir, tlr;

  tap_controller u_tap (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .tms_i        (bus.tms_i),
    .state_o      (tap_state),
    .capture_dr_o (capture_dr),
    .shift_dr_o   (shift_dr),
    .update_dr_o  (update_dr),
    .capture_ir_o (capture_ir),
    .shift_ir_o   (shift_ir),
    .update_ir_o  (update_ir),
    .tlr_o        (tlr)
  );

  logic [IR_WIDTH-1:0] ir_sh_q, ir_sh_d, ir_upd_q, ir_upd_d;
  logic [N_CELLS-1:0]  bsr_sh_q, bsr_sh_d, bsr_upd_q, bsr_upd_d;
  logic                byp_q, byp_d;
  logic                bsr_sel, extest;

  assign extest  = (ir_upd_q == IR_EXTEST);
  assign bsr_sel = extest || (ir_upd_q == IR_SAMPLE);

  always_comb begin
    ir_sh_d   = ir_sh_q;
    ir_upd_d  = ir_upd_q;
    bsr_sh_d  = bsr_sh_q;
    bsr_upd_d = bsr_upd_q;
    byp_d     = byp_q;

    if (capture_ir) begin
      ir_sh_d = IR_CAPTURE;
    end else if (shift_ir) begin
      ir_sh_d = ir_sh_q >> 1;
      ir_sh_d[IR_WIDTH-1] = bus.tdi_i;
    end

    if (tlr)            ir_upd_d = IR_BYPASS;
    else if (update_ir) ir_upd_d = ir_sh_q;

    if (capture_dr && bsr_sel) begin
      bsr_sh_d = bus.core_in_i;
    end else if (shift_dr && bsr_sel) begin
      bsr_sh_d = bsr_sh_q >> 1;
      bsr_sh_d[N_CELLS-1] = bus.tdi_i;
    end

    if (update_dr && bsr_sel) bsr_upd_d = bsr_sh_q;

    if (capture_dr && !bsr_sel) byp_d = 1'b0;
    else if (shift_dr)          byp_d = bus.tdi_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ir_sh_q   <= '0;
      ir_upd_q  <= IR_BYPASS;
      bsr_sh_q  <= '0;
      bsr_upd_q <= '0;
      byp_q     <= 1'b0;
    end else begin
      ir_sh_q   <= ir_sh_d;
      ir_upd_q  <= ir_upd_d;
      bsr_sh_q  <= bsr_sh_d;
      bsr_upd_q <= bsr_upd_d;
      byp_q     <= byp_d;
    end
  end

  always_comb begin
    bus.tdo_o = 1'b0;
    if (shift_ir)      bus.tdo_o = ir_sh_q[0];
    else if (shift_dr) bus.tdo_o = bsr_sel ? bsr_sh_q[0] : byp_q;
  end

  assign bus.tdo_en_o  = (tap_state == SHIFT_DR) || (tap_state == SHIFT_IR);
  // Reset forces the IR to BYPASS, so pins fall back to the core asynchronously.
  assign bus.pin_out_o = extest ? bsr_upd_q : bus.core_in_i;

endmodule

// File: doc/boundary_scan_chain.md
Name: boundary_scan_chain

Overview:
- Parametrised boundary-scan register of N_CELLS cells, each sitting between a core output and its pin, with an integrated 16-state IEEE 1149.1-style TAP controller, instruction register and bypass register.
- Replaces hand-wired single cells. It adds chain length, instruction decode (EXTEST, SAMPLE/PRELOAD, BYPASS) and capture/shift/update sequencing driven from TMS instead of separate strobes.
- Whole block runs on one clock (TCK).

Parameters:
- N_CELLS, 8, number of boundary cells (≥1).
- IR_WIDTH, 2, instruction register width (≥2).

Ports:
- Clock  input  1  TCK; all state changes on the rising edge.
- Reset_n  input  1  asynchronous, active-low reset (TRST*).
- TMS  input  1  test mode select.
- TDI  input  1  serial data in.
- TDO  output  1  serial data out.
- TDO_en  output  1  high while in Shift-DR or Shift-IR.
- Core_in  input  N_CELLS  system data from core.
- Pin_out  output  N_CELLS  data driven to pins.

Behaviour:
- Reset (Reset_n=0, async):
  - FSM = Test-Logic-Reset (TLR).
  - IR update reg = BYPASS (all ones); IR shift reg = 0.
  - BSR shift and update regs = 0; bypass flop = 0.
  - TDO=0, TDO_en=0, Pin_out=Core_in combinationally.
- TAP FSM: standard 16 states with standard TMS transitions.
  - TLR –TMS0→ Run-Test/Idle (RTI).
  - Select-DR –1→ Select-IR –1→ TLR.
  - Five TMS=1 edges reach TLR from any state.
  - While in TLR, IR is held at BYPASS synchronously.
- Actions, executed on the rising edge at which the FSM is currently in the named state:
  - Capture-DR:
    - BSR selected: BSR shift reg <= Core_in.
    - BYPASS selected: bypass <= 0.
  - Shift-DR: selected register shifts one place toward bit 0; TDI enters the MSB; bypass <= TDI.
  - Update-DR: if BSR selected, BSR update reg <= BSR shift reg.
  - Capture-IR: IR shift reg <= {0…,01} (LSBs 01).
  - Shift-IR: IR shift reg shifts with TDI into the MSB.
  - Update-IR: IR update reg <= IR shift reg.
  - A shift also occurs on the edge that exits Shift-xR with TMS=1.
- Instruction decode (IR update reg):
  - 00 EXTEST.
  - 01 SAMPLE/PRELOAD.
  - all ones BYPASS.
  - Any other code decodes as BYPASS.
  - BSR is selected for EXTEST and SAMPLE/PRELOAD; the bypass flop is selected otherwise.
- TDO is combinational:
  - Shift-IR: IR shift reg[0].
  - Shift-DR: selected register bit 0 (the bypass flop when BYPASS is selected).
  - Otherwise: 0.
- Pin_out: equals BSR update reg only while the IR update reg = EXTEST; otherwise Core_in. Switching happens in the same cycle the IR update reg changes.
- Update reg holds across non-EXTEST instructions, so PRELOAD followed by EXTEST drives the preloaded value with no glitch to stale data.
- Async reset mid-operation: all state is abandoned immediately and Pin_out reverts to Core_in without waiting for a clock.
- Latency: an N_CELLS-bit DR scan needs exactly N_CELLS Shift-DR edges. The bypass path delays TDI→TDO by one edge.

Decomposition:
- Shared package bscan_pkg:
  - TAP state enum (4-bit encoding).
  - Opcode constants OP_EXTEST, OP_SAMPLE, OP_BYPASS.
  - Default IR_WIDTH.
- Sub-module tap_controller:
  - Input: TMS.
  - Output: state plus decoded one-hot strobes capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir, tlr.
- Top level holds the IR, BSR shift/update vectors, bypass flop and the TDO mux.

Test Plan:
- Reset_n pulsed low mid-RTI with Core_in=8'h5A → state TLR, Pin_out=8'h5A, TDO_en=0, IR=2'b11.
- From Shift-DR, TMS=1 for 5 edges → TLR; IR reads BYPASS. Then TMS=0 → RTI.
- Load IR=01 (captured IR bits on TDO are 1,0). Capture-DR with Core_in=8'hA5, then 8 Shift-DR edges with TDI=0:
  - TDO sequence 1,0,1,0,0,1,0,1.
  - Pin_out follows Core_in throughout.
- PRELOAD: shift 8'h3C (LSB first), Update-DR; Pin_out still = Core_in. Then load IR=00 (EXTEST):
  - Pin_out=8'h3C after Update-IR.
  - Changing Core_in to 8'hFF leaves Pin_out=8'h3C.
- BYPASS: Capture-DR, shift TDI=1,0,1,1 → TDO=0,1,0,1 (one-edge delay, first bit 0); TDO_en=1 only during Shift-DR.
- EXTEST driving 8'h3C, assert Reset_n=0 mid Shift-DR without a clock edge → Pin_out=Core_in immediately; after release, IR=BYPASS and BSR update reg=0.
